// File: rtl/level_debounce_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared state encodings and default parameters for the level debounce controller.
package level_debounce_ctrl_pkg;

   localparam logic [1:0] ST_ZERO    = 2'b00;
   localparam logic [1:0] ST_DB_RISE = 2'b01;
   localparam logic [1:0] ST_ONE     = 2'b10;
   localparam logic [1:0] ST_DB_FALL = 2'b11;

   typedef enum logic [1:0] {
      ZERO    = ST_ZERO,
      DB_RISE = ST_DB_RISE,
      ONE     = ST_ONE,
      DB_FALL = ST_DB_FALL
   } db_state_t;

   localparam int DEF_DB_CYCLES     = 4;
   localparam int DEF_REPEAT_CYCLES = 16;
   localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/level_debounce_ctrl_if.sv
`timescale 1ns/1ps
// Pad-side level input and one-cycle event outputs of the debounce controller.
interface level_debounce_ctrl_if
   import level_debounce_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             level;
   logic             tick;
   logic             rel_tick;
   logic             stable_level;
   logic [CNT_W-1:0] press_cnt;

   modport master (
      output level,
      input  tick,
      input  rel_tick,
      input  stable_level,
      input  press_cnt
   );

   modport slave (
      input  level,
      output tick,
      output rel_tick,
      output stable_level,
      output press_cnt
   );
endinterface

// File: rtl/level_debounce_ctrl_sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchronizer for a single asynchronous pad input, reset low to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/level_debounce_ctrl.sv
`timescale 1ns/1ps
// Debounces a synchronized pad level and turns confirmed edges into one-cycle
// press/release ticks, with optional auto-repeat and a saturating press count.
module level_debounce_ctrl
   import level_debounce_ctrl_pkg::*;
#(
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
)(
   input logic                 clk,
   input logic                 rst,
   level_debounce_ctrl_if.slave bus
);
   localparam logic [7:0]  DB_LAST  = 8'(DB_CYCLES - 1);
   localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
   localparam bit          REP_EN   = (REPEAT_CYCLES != 0);

   db_state_t        state;
   logic             level_s;
   logic [7:0]       db_cnt;
   logic [15:0]      rep_cnt;
   logic             tick;
   logic             rel_tick;
   logic             stable_level;
   logic [CNT_W-1:0] press_cnt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.level),
      .q   (level_s)
   );

   // Outputs are written on the same edge as the transition that causes them,
   // so ticks default low and only the confirming branch raises them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ZERO;
         db_cnt       <= '0;
         rep_cnt      <= '0;
         tick         <= 1'b0;
         rel_tick     <= 1'b0;
         stable_level <= 1'b0;
         press_cnt    <= '0;
      end else begin
         tick     <= 1'b0;
         rel_tick <= 1'b0;
         case (state)
            ZERO: begin
               if (level_s) begin
                  state  <= DB_RISE;
                  db_cnt <= '0;
               end
            end
            DB_RISE: begin
               if (!level_s) begin
                  state <= ZERO;
               end else if (db_cnt == DB_LAST) begin
                  state        <= ONE;
                  tick         <= 1'b1;
                  stable_level <= 1'b1;
                  rep_cnt      <= '0;
                  if (press_cnt != {CNT_W{1'b1}}) begin
                     press_cnt <= press_cnt + CNT_W'(1);
                  end
               end else begin
                  db_cnt <= db_cnt + 8'd1;
               end
            end
            ONE: begin
               if (!level_s) begin
                  state  <= DB_FALL;
                  db_cnt <= '0;
               end else if (REP_EN) begin
                  if (rep_cnt == REP_LAST) begin
                     tick    <= 1'b1;
                     rep_cnt <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 16'd1;
                  end
               end
            end
            DB_FALL: begin
               // A bounce back high resumes the hold with a fresh repeat interval.
               if (level_s) begin
                  state   <= ONE;
                  rep_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state        <= ZERO;
                  rel_tick     <= 1'b1;
                  stable_level <= 1'b0;
               end else begin
                  db_cnt <= db_cnt + 8'd1;
               end
            end
            default: state <= ZERO;
         endcase
      end
   end

   assign bus.tick         = tick;
   assign bus.rel_tick     = rel_tick;
   assign bus.stable_level = stable_level;
   assign bus.press_cnt    = press_cnt;
endmodule
